layer2_sequencer: RTL and testbench

//   Sequences one shared layer2_neuron over all NUM_OUT output neurons of Layer 2.

---
 rtl/layer2_sequencer.sv | 146 ++++++++++++++
 tb/tb_layer2_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/layer2_sequencer.sv
// Time-multiplexes one layer2_neuron across NUM_OUT classes and reports the signed argmax.
// Optional logit stream: define LAYER2_SEQ_LOGIT_STREAM_EN.
module layer2_sequencer #(
  parameter  int NUM_OUT = 10,
  parameter  int NUM_IN  = 48,
  localparam int IW      = $clog2(NUM_OUT),
  localparam int AW      = $clog2(NUM_OUT*NUM_IN),
  localparam int MW      = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_IN-1:0] act_bits,
  output logic              busy,
  output logic              done,
  output logic [IW-1:0]     class_idx,
  output logic [5:0]        class_score,
  output logic [AW-1:0]     w_addr,
  input  logic [1:0]        w_data,
  output logic [IW-1:0]     b_addr,
  input  logic [3:0]        b_data,
  output logic              n_start,
  output logic [1:0]        n_input_val,
  output logic [1:0]        n_weight,
  output logic [3:0]        n_bias,
  input  logic              n_done,
  input  logic [5:0]        n_result,
  input  logic [5:0]        n_mac_count,
  output logic              logit_valid,
  output logic [IW-1:0]     logit_idx,
  output logic [5:0]        logit
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RELEASE, S_FINISH} state_t;

  state_t            state_q;
  logic [IW-1:0]     nidx_q;
  logic [NUM_IN-1:0] act_q;
  logic [IW-1:0]     best_idx_q;
  logic [5:0]        best_score_q;
  logic              busy_q, done_q, n_start_q;
  logic [IW-1:0]     class_idx_q;
  logic [5:0]        class_score_q;
  logic [MW-1:0]     mac_idx;
  logic              capture;

  // Out-of-range MAC index (neuron idle / finishing) falls back to input 0.
  assign mac_idx     = (n_mac_count < 6'(NUM_IN)) ? MW'(n_mac_count) : '0;
  assign n_input_val = act_q[mac_idx] ? 2'b01 : 2'b11;
  assign w_addr      = AW'(nidx_q) * AW'(NUM_IN) + AW'(mac_idx);
  assign b_addr      = nidx_q;
  assign n_weight    = w_data;
  assign n_bias      = b_data;
  assign capture     = (state_q == S_WAIT) && n_done;

  assign busy        = busy_q;
  assign done        = done_q;
  assign n_start     = n_start_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      nidx_q        <= '0;
      act_q         <= '0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      n_start_q     <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          act_q   <= act_bits;
          nidx_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= S_LAUNCH;
        end
        S_LAUNCH: begin
          n_start_q <= 1'b1;
          state_q   <= S_WAIT;
        end
        S_WAIT: if (n_done) begin
          // Strict compare so ties keep the lower class index.
          if (nidx_q == '0 || $signed(n_result) > $signed(best_score_q)) begin
            best_score_q <= n_result;
            best_idx_q   <= nidx_q;
          end
          n_start_q <= 1'b0;
          state_q   <= S_RELEASE;
        end
        S_RELEASE: if (!n_done) begin
          if (nidx_q == IW'(NUM_OUT-1)) begin
            state_q <= S_FINISH;
          end else begin
            nidx_q  <= nidx_q + IW'(1);
            state_q <= S_LAUNCH;
          end
        end
        S_FINISH: begin
          class_idx_q   <= best_idx_q;
          class_score_q <= best_score_q;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef LAYER2_SEQ_LOGIT_STREAM_EN
  logic          lv_q;
  logic [IW-1:0] lidx_q;
  logic [5:0]    logit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lv_q    <= 1'b0;
      lidx_q  <= '0;
      logit_q <= '0;
    end else begin
      lv_q <= capture;
      if (capture) begin
        lidx_q  <= nidx_q;
        logit_q <= n_result;
      end
    end
  end

  assign logit_valid = lv_q;
  assign logit_idx   = lidx_q;
  assign logit       = logit_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign logit_valid    = 1'b0;
  assign logit_idx      = '0;
  assign logit          = '0;
`endif

endmodule

// File: tb/tb_layer2_sequencer.sv
// Directed bench for layer2_sequencer with a behavioural neuron and combinational weight/bias ROMs.
module tb_layer2_sequencer;
  localparam int NUM_OUT = 10;
  localparam int NUM_IN  = 48;
  localparam int IW = $clog2(NUM_OUT);
  localparam int AW = $clog2(NUM_OUT*NUM_IN);

  logic              clk = 0, rst = 1, start = 0;
  logic [NUM_IN-1:0] act_bits = '0;
  logic              busy, done, n_start, n_done, logit_valid;
  logic [IW-1:0]     class_idx, b_addr, logit_idx;
  logic [5:0]        class_score, n_result, n_mac_count, logit;
  logic [AW-1:0]     w_addr;
  logic [1:0]        w_data, n_input_val, n_weight;
  logic [3:0]        b_data, n_bias;

  logic [1:0] wmem [NUM_OUT*NUM_IN];
  logic [3:0] bmem [NUM_OUT];
  assign w_data = wmem[w_addr];
  assign b_data = bmem[b_addr];

  int tests = 0, fails = 0, done_cnt = 0;
  int lv_idx[$];
  int lv_val[$];

  always #5 clk = ~clk;

  layer2_sequencer #(.NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .rst(rst), .start(start), .act_bits(act_bits),
    .busy(busy), .done(done), .class_idx(class_idx), .class_score(class_score),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .n_start(n_start), .n_input_val(n_input_val), .n_weight(n_weight), .n_bias(n_bias),
    .n_done(n_done), .n_result(n_result), .n_mac_count(n_mac_count),
    .logit_valid(logit_valid), .logit_idx(logit_idx), .logit(logit)
  );

  // Neuron model: 48 MAC cycles, one bias cycle, then done held until start drops.
  logic [1:0] nst;
  logic [5:0] cnt;
  int         acc;
  assign n_mac_count = cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nst <= 0; cnt <= 0; acc <= 0; n_done <= 0; n_result <= 0;
    end else begin
      case (nst)
        2'd0: if (n_start) begin cnt <= 0; acc <= 0; nst <= 1; end
        2'd1: begin
          acc <= acc + int'($signed(n_input_val)) * int'($signed(n_weight));
          cnt <= cnt + 6'd1;
          if (cnt == 6'(NUM_IN-1)) nst <= 2;
        end
        2'd2: begin
          n_result <= 6'(acc + int'($signed(n_bias)));
          n_done   <= 1;
          nst      <= 3;
        end
        default: if (!n_start) begin n_done <= 0; cnt <= 0; nst <= 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (logit_valid) begin
      lv_idx.push_back(int'(logit_idx));
      lv_val.push_back(int'($signed(logit)));
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // mode 1: w=0 b=k-5; 2: w=0 b=3; 3: w=+1 for i<k, b=0; 4: n2 w=-1, all b=-8
  task automatic load_rom(input int mode);
    for (int k = 0; k < NUM_OUT; k++) begin
      case (mode)
        1: bmem[k] = 4'(k - 5);
        2: bmem[k] = 4'd3;
        3: bmem[k] = 4'd0;
        default: bmem[k] = 4'b1000;
      endcase
      for (int i = 0; i < NUM_IN; i++) begin
        case (mode)
          3: wmem[k*NUM_IN+i] = (i < k) ? 2'b01 : 2'b00;
          4: wmem[k*NUM_IN+i] = (k == 2) ? 2'b11 : 2'b00;
          default: wmem[k*NUM_IN+i] = 2'b00;
        endcase
      end
    end
  endtask

  task automatic run(input string tag, input logic [NUM_IN-1:0] a, input int eidx,
                     input int escore, input bit poke);
    int cyc;
    @(posedge clk); #1;
    act_bits = a; start = 1;
    @(posedge clk); #1;
    start = 0; act_bits = ~a;
    chk({tag, ".busy"}, int'(busy), 1);
    cyc = 0;
    while (!done && cyc < 700) begin
      if (poke && (cyc == 100 || cyc == 300)) start = 1;
      @(posedge clk); #1;
      start = 0;
      cyc++;
    end
    chk({tag, ".done_seen"}, int'(done), 1);
    chk({tag, ".latency_ok"}, int'(cyc <= 553), 1);
    chk({tag, ".idx"}, int'(class_idx), eidx);
    chk({tag, ".score"}, int'($signed(class_score)), escore);
    @(posedge clk); #1;
    chk({tag, ".busy_clr"}, int'(busy), 0);
  endtask

  initial begin
    int d0, w;
    load_rom(1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.n_start", int'(n_start), 0);
    chk("rst.lv", int'(logit_valid), 0);
    rst = 0;
    @(posedge clk); #1;
    chk("idle.idx", int'(class_idx), 0);
    chk("idle.score", int'(class_score), 0);

    load_rom(1); run("t1", 48'h5A5A_0F0F_1234, 9, 4, 0);
`ifdef LAYER2_SEQ_LOGIT_STREAM_EN
    chk("t6.count", lv_idx.size(), NUM_OUT);
    for (int k = 0; k < NUM_OUT && k < lv_idx.size(); k++) begin
      chk($sformatf("t6.idx%0d", k), lv_idx[k], k);
      chk($sformatf("t6.logit%0d", k), lv_val[k], k - 5);
    end
`endif
    load_rom(2); run("t2", '0, 0, 3, 0);
    load_rom(3); run("t3", '1, 9, 9, 0);
    // Neuron 2 wraps 40 -> -24; the rest tie at -8 so the lowest index wins.
    load_rom(4); run("t4", '0, 0, -8, 0);
    load_rom(1);
    d0 = done_cnt;
    run("t5", 48'hFFFF_0000_FFFF, 9, 4, 1);
    repeat (600) @(posedge clk);
    #1;
    chk("t5.one_done", done_cnt - d0, 1);
    chk("t5.still_idle", int'(busy), 0);

    // Reset while neuron 4 is running.
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    w = 0;
    while (!(b_addr == IW'(4) && n_start) && w < 700) begin
      @(posedge clk); #1;
      w++;
    end
    chk("t5r.reached_n4", int'(w < 700), 1);
    repeat (10) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t5r.busy", int'(busy), 0);
    chk("t5r.n_start", int'(n_start), 0);
    chk("t5r.idx", int'(class_idx), 0);
    chk("t5r.score", int'(class_score), 0);
    chk("t5r.done", int'(done), 0);
    @(posedge clk); #1;
    rst = 0;
    lv_idx.delete(); lv_val.delete();
    run("t5n", 48'h1, 9, 4, 0);
`ifdef LAYER2_SEQ_LOGIT_STREAM_EN
    chk("t5n.lv_count", lv_idx.size(), NUM_OUT);
`else
    chk("t6.lv_none", lv_idx.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
